fsk_light_transmitter: RTL and testbench

- Test-stimulus source for the frequency analysis chain: emits a serial bit pattern as a frequency-shift-keyed square wave on one light/LED output.
- Bit 0 is sent at FREQUENCY0 and bit 1 at FREQUENCY1, for one symbol period each, followed by a dark guard interval.
- Drives the optical target that frequency_analyzer channels measure; start/stop/done let software or the manager frame a capture window around a transmission.

---
 rtl/fsk_light_transmitter_pkg.sv | 20 ++
 rtl/fsk_light_transmitter_square_wave_generator.sv | 30 +++
 rtl/fsk_light_transmitter.sv | 133 +++++++++++++
 tb/tb_fsk_light_transmitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_light_transmitter_pkg.sv
// Shared state encoding and tone half-period helper for the FSK light transmitter.
package fsk_light_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EMIT   = 3'd1,
        ST_GUARD  = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Clocks per half tone period, never below one so the wave always toggles.
    function automatic logic [31:0] half_period(input int unsigned clock_hz,
                                                input int unsigned tone_hz);
        int unsigned h;
        h = clock_hz / (2 * tone_hz);
        return (h == 0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/fsk_light_transmitter_square_wave_generator.sv
// Free-running square wave with a programmable half period; restart forces phase high.
module square_wave_generator (
    input  logic        clock,
    input  logic        aresetn,
    input  logic        restart,
    input  logic [31:0] half_period,
    output logic        wave
);

    logic [31:0] half_count;
    logic        phase;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            half_count <= '0;
            phase      <= 1'b1;
        end else if (restart) begin
            half_count <= '0;
            phase      <= 1'b1;
        end else if (half_count == half_period - 32'd1) begin
            half_count <= '0;
            phase      <= ~phase;
        end else begin
            half_count <= half_count + 32'd1;
        end
    end

    assign wave = phase;

endmodule

// File: rtl/fsk_light_transmitter.sv
// Sends a serial bit pattern as FSK tone bursts on one LED, with dark guard gaps.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for start; pattern/length/repeat captured on accept
// ST_EMIT   | tone burst for the current symbol, SYMBOL_CLOCKS long
// ST_GUARD  | forced dark for GUARD_CLOCKS
// ST_NEXT   | one cycle: advance index, wrap on repeat, or finish
// ST_FINISH | one cycle: raises done on the way back to idle
module fsk_light_transmitter
    import fsk_light_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned FREQUENCY0      = 5000,
    parameter int unsigned FREQUENCY1      = 10000,
    parameter int unsigned SYMBOL_CLOCKS   = 1000000,
    parameter int unsigned GUARD_CLOCKS    = 100000,
    parameter int unsigned PATTERN_WIDTH   = 32
) (
    input  logic                               s00_axi_aclk,
    input  logic                               s00_axi_aresetn,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               repeat_en,
    input  logic [PATTERN_WIDTH-1:0]           pattern,
    input  logic [$clog2(PATTERN_WIDTH):0]     pattern_length,
    output logic                               led,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(PATTERN_WIDTH)-1:0]   symbol_index
);

    localparam int IW = $clog2(PATTERN_WIDTH);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] MAX_LEN    = LW'(PATTERN_WIDTH);
    localparam logic [31:0]   HALF0      = half_period(CLOCK_FREQUENCY, FREQUENCY0);
    localparam logic [31:0]   HALF1      = half_period(CLOCK_FREQUENCY, FREQUENCY1);
    localparam logic [31:0]   SYM_LOAD   = SYMBOL_CLOCKS - 32'd1;
    localparam logic [31:0]   GUARD_LOAD = GUARD_CLOCKS - 32'd1;

    state_t state, state_next;

    logic [PATTERN_WIDTH-1:0] pat_q;
    logic [LW-1:0]            len_q;
    logic                     rep_q;
    logic [IW-1:0]            idx_q;
    logic [31:0]              timer;
    logic [LW-1:0]            len_clamped;
    logic                     accept;
    logic                     more;
    logic [31:0]              half;
    logic                     wave;
    logic                     led_d, busy_d, done_d;

    assign len_clamped = (pattern_length > MAX_LEN) ? MAX_LEN : pattern_length;
    assign accept      = (state == ST_IDLE) && start && !stop;
    assign more        = ({1'b0, idx_q} + LW'(1)) < len_q;
    assign half        = pat_q[idx_q] ? HALF1 : HALF0;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= ST_IDLE;
        else                  state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (accept) state_next = (len_clamped == '0) ? ST_FINISH : ST_EMIT;
            ST_EMIT:   if (timer == 32'd0) state_next = (GUARD_CLOCKS == 0) ? ST_NEXT : ST_GUARD;
            ST_GUARD:  if (timer == 32'd0) state_next = ST_NEXT;
            ST_NEXT:   state_next = (more || rep_q) ? ST_EMIT : ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (stop && state != ST_IDLE) state_next = ST_IDLE;
    end

    always_comb begin
        led_d  = (state == ST_EMIT) && wave && !stop;
        busy_d = (state != ST_IDLE) && !stop;
        done_d = (state == ST_FINISH) && !stop;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            led  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            led  <= led_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pat_q <= '0;
            len_q <= '0;
            rep_q <= 1'b0;
            idx_q <= '0;
            timer <= '0;
        end else begin
            if (accept) begin
                pat_q <= pattern;
                len_q <= len_clamped;
                rep_q <= repeat_en;
                idx_q <= '0;
            end else if (state == ST_NEXT && !stop) begin
                if (more)       idx_q <= idx_q + IW'(1);
                else if (rep_q) idx_q <= '0;
            end
            // One down-counter serves both the burst and the guard interval.
            if (state_next == ST_EMIT && state != ST_EMIT)
                timer <= SYM_LOAD;
            else if (state_next == ST_GUARD && state != ST_GUARD)
                timer <= GUARD_LOAD;
            else if (timer != 32'd0)
                timer <= timer - 32'd1;
        end
    end

    assign symbol_index = idx_q;

    square_wave_generator u_wave (
        .clock       (s00_axi_aclk),
        .aresetn     (s00_axi_aresetn),
        .restart     (state != ST_EMIT),
        .half_period (half),
        .wave        (wave)
    );

endmodule

// File: tb/tb_fsk_light_transmitter.sv
// Directed bench: records one window of outputs per transmission and checks it.
module tb_fsk_light_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       repeat_en = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pattern_length = '0;
    logic       led, busy, done;
    logic [2:0] symbol_index;

    int checks = 0;
    int errors = 0;

    logic       led_h  [0:299];
    logic       busy_h [0:299];
    logic       done_h [0:299];
    logic [2:0] idx_h  [0:299];

    always #5 clk = ~clk;

    fsk_light_transmitter #(
        .CLOCK_FREQUENCY (1000),
        .FREQUENCY0      (50),
        .FREQUENCY1      (100),
        .SYMBOL_CLOCKS   (100),
        .GUARD_CLOCKS    (20),
        .PATTERN_WIDTH   (8)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .start           (start),
        .stop            (stop),
        .repeat_en       (repeat_en),
        .pattern         (pattern),
        .pattern_length  (pattern_length),
        .led             (led),
        .busy            (busy),
        .done            (done),
        .symbol_index    (symbol_index)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int k);
        @(posedge clk);
        #1;
        led_h[k]  = led;
        busy_h[k] = busy;
        done_h[k] = done;
        idx_h[k]  = symbol_index;
    endtask

    task automatic run(input int a, input int b);
        for (int k = a; k <= b; k++) sample(k);
    endtask

    // Index 0 of the window is the edge that accepts start.
    task automatic launch(input logic [7:0] pat, input logic [3:0] len, input logic rep);
        pattern        = pat;
        pattern_length = len;
        repeat_en      = rep;
        start          = 1'b1;
        sample(0);
        start          = 1'b0;
    endtask

    function automatic int rises(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) if (led_h[k] === 1'b1 && led_h[k-1] === 1'b0) n++;
        return n;
    endfunction

    function automatic int first_rise(input int a, input int b);
        for (int k = a; k <= b; k++) if (led_h[k] === 1'b1 && led_h[k-1] === 1'b0) return k;
        return -1;
    endfunction

    function automatic int ones_led(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) if (led_h[k] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int ones_busy(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) if (busy_h[k] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int ones_done(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) if (done_h[k] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int first_done(input int a, input int b);
        for (int k = a; k <= b; k++) if (done_h[k] === 1'b1) return k;
        return -1;
    endfunction

    initial begin
        #2;
        check("reset_led",  32'(led),  0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_idx",  32'(symbol_index), 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single bit '1'
        launch(8'b1, 4'd1, 1'b0);
        run(1, 140);
        check("single_first_rise", first_rise(1, 140), 1);
        check("single_rises",      rises(1, 100), 10);
        check("single_dark",       ones_led(101, 140), 0);
        check("single_busy_len",   ones_busy(1, 140), 122);
        check("single_done_at",    first_done(1, 140), 122);
        check("single_done_cnt",   ones_done(1, 140), 1);

        // mixed pattern 0b10: slow tone then fast tone
        launch(8'b10, 4'd2, 1'b0);
        run(1, 260);
        check("mixed_sym0_rises",  rises(1, 100), 5);
        check("mixed_sym0_second", first_rise(2, 100), 21);
        check("mixed_sym1_rises",  rises(101, 240), 10);
        check("mixed_sym1_first",  first_rise(101, 240), 122);
        check("mixed_sym1_second", first_rise(123, 240), 132);
        check("mixed_idx0",        32'(idx_h[50]), 0);
        check("mixed_idx1",        32'(idx_h[150]), 1);
        check("mixed_done_at",     first_done(1, 260), 243);
        check("mixed_done_cnt",    ones_done(1, 260), 1);
        check("mixed_busy_len",    ones_busy(1, 260), 243);

        // zero length
        launch(8'hFF, 4'd0, 1'b0);
        run(1, 20);
        check("zero_done_at",  first_done(1, 20), 1);
        check("zero_done_cnt", ones_done(1, 20), 1);
        check("zero_led",      ones_led(0, 20), 0);

        // abort a repeating transmission
        launch(8'hFF, 4'd8, 1'b1);
        run(1, 249);
        check("abort_busy_before", 32'(busy_h[249]), 1);
        check("abort_idx_before",  32'(idx_h[249]), 2);
        stop = 1'b1;
        sample(250);
        stop = 1'b0;
        check("abort_led",  32'(led_h[250]), 0);
        check("abort_busy", 32'(busy_h[250]), 0);
        run(251, 280);
        check("abort_idle_busy", ones_busy(251, 280), 0);
        check("abort_idle_led",  ones_led(251, 280), 0);
        check("abort_no_done",   ones_done(1, 280), 0);

        // restart after abort
        launch(8'b1, 4'd1, 1'b0);
        run(1, 140);
        check("restart_done_at",  first_done(1, 140), 122);
        check("restart_busy_len", ones_busy(1, 140), 122);

        // repeat wraps the index instead of finishing; stop during a high phase
        launch(8'b01, 4'd2, 1'b1);
        run(1, 244);
        check("wrap_idx1",     32'(idx_h[150]), 1);
        check("wrap_idx0",     32'(idx_h[244]), 0);
        check("wrap_led_high", 32'(led_h[244]), 1);
        check("wrap_busy",     32'(busy_h[244]), 1);
        stop = 1'b1;
        sample(245);
        stop = 1'b0;
        check("wrap_stop_led",  32'(led_h[245]), 0);
        check("wrap_stop_busy", 32'(busy_h[245]), 0);
        run(246, 250);
        check("wrap_no_done", ones_done(1, 250), 0);

        // start with stop in the same cycle is ignored
        pattern        = 8'b1;
        pattern_length = 4'd1;
        start          = 1'b1;
        stop           = 1'b1;
        sample(0);
        start          = 1'b0;
        stop           = 1'b0;
        run(1, 10);
        check("startstop_busy", ones_busy(0, 10), 0);
        check("startstop_led",  ones_led(0, 10), 0);

        // second start while busy is ignored
        launch(8'b1, 4'd1, 1'b0);
        run(1, 49);
        pattern        = 8'h00;
        pattern_length = 4'd0;
        start          = 1'b1;
        sample(50);
        start          = 1'b0;
        run(51, 140);
        check("ignore_rises",    rises(1, 100), 10);
        check("ignore_done_at",  first_done(1, 140), 122);
        check("ignore_done_cnt", ones_done(1, 140), 1);
        check("ignore_busy_len", ones_busy(1, 140), 122);

        // asynchronous reset in the middle of a symbol
        launch(8'b1, 4'd1, 1'b0);
        run(1, 37);
        check("areset_busy_before", 32'(busy_h[37]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_led",  32'(led),  0);
        check("areset_busy", 32'(busy), 0);
        check("areset_done", 32'(done), 0);
        #10 rst_n = 1'b1;
        run(1, 30);
        check("areset_idle_busy", ones_busy(1, 30), 0);
        check("areset_idle_led",  ones_led(1, 30), 0);
        check("areset_idle_done", ones_done(1, 30), 0);
        launch(8'b1, 4'd1, 1'b0);
        run(1, 5);
        check("areset_new_busy", 32'(busy_h[1]), 1);
        check("areset_new_led",  32'(led_h[1]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
